// File: rtl/middle_ram_sequencer.sv
// Frame sequencer: raster-writes one frame of producer pixels into a middle RAM,
// then raster-reads it back to a consumer with back-pressure over a 1-cycle-latency read port.
`timescale 1ns/1ps
module middle_ram_sequencer #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oDone,
    input  logic                   iInValid,
    input  logic [7:0]             iInData,
    output logic                   oInReady,
    output logic                   oWren,
    output logic [WIDTH_BITS-1:0]  oWrcol,
    output logic [HEIGHT_BITS-1:0] oWrrow,
    output logic [7:0]             oWrdata,
    output logic [WIDTH_BITS-1:0]  oRdcol,
    output logic [HEIGHT_BITS-1:0] oRdrow,
    input  logic [7:0]             iRddata,
    output logic                   oOutValid,
    output logic [7:0]             oOutData,
    input  logic                   iOutReady
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                 state, state_nx;
    logic [WIDTH_BITS-1:0]  wrcol, rdcol, outcol;
    logic [HEIGHT_BITS-1:0] wrrow, rdrow, outrow;
    logic                   outvalid;

    logic wr_hs, wr_last, rd_last, stall, issue, accept;

    assign wr_hs   = (state == WRITE) & iInValid;
    assign wr_last = (&wrcol) & (&wrrow);
    assign rd_last = (&rdcol) & (&rdrow);
    assign stall   = outvalid & ~iOutReady;
    assign issue   = (state == READ) & ~stall;
    assign accept  = outvalid & iOutReady;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iStart)            state_nx = WRITE;
            WRITE:   if (wr_hs && wr_last)  state_nx = READ;
            READ:    if (issue && rd_last)  state_nx = DRAIN;
            DRAIN:   if (accept)            state_nx = DONE;
            DONE:                           state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    // outcol/outrow track the address whose data is currently on oOutData
    always_ff @(posedge clock) begin
        if (reset) begin
            wrcol    <= '0;
            wrrow    <= '0;
            rdcol    <= '0;
            rdrow    <= '0;
            outcol   <= '0;
            outrow   <= '0;
            outvalid <= 1'b0;
        end else begin
            if (state == IDLE && iStart) begin
                wrcol    <= '0;
                wrrow    <= '0;
                rdcol    <= '0;
                rdrow    <= '0;
                outvalid <= 1'b0;
            end
            if (wr_hs) begin
                wrcol <= wrcol + 1'b1;
                if (&wrcol) wrrow <= wrrow + 1'b1;
                if (wr_last) begin
                    rdcol    <= '0;
                    rdrow    <= '0;
                    outvalid <= 1'b0;
                end
            end
            if (issue) begin
                outcol   <= rdcol;
                outrow   <= rdrow;
                rdcol    <= rdcol + 1'b1;
                if (&rdcol) rdrow <= rdrow + 1'b1;
                outvalid <= 1'b1;
            end else if (state == DRAIN && accept) begin
                outvalid <= 1'b0;
            end
        end
    end

    // A stall (or the drain of the last pixel) re-presents the held address so iRddata stays put
    always_comb begin
        oRdcol = rdcol;
        oRdrow = rdrow;
        if (stall || state == DRAIN) begin
            oRdcol = outcol;
            oRdrow = outrow;
        end
    end

    assign oBusy     = (state != IDLE);
    assign oDone     = (state == DONE);
    assign oInReady  = (state == WRITE);
    assign oWren     = iInValid & oInReady;
    assign oWrcol    = wrcol;
    assign oWrrow    = wrrow;
    assign oWrdata   = iInData;
    assign oOutValid = outvalid & ((state == READ) | (state == DRAIN));
    assign oOutData  = iRddata;
endmodule

// File: tb/tb_middle_ram_sequencer.sv
// Bench: a 4x4 instance driven with directed frames and a 32x16 instance with random
// valid/stall patterns, both compared against the raster order of the pixels sent.
`timescale 1ns/1ps
module tb_middle_ram_sequencer;
    localparam int BW = 5, BH = 4, BN = 1 << (BW + BH);

    logic clock = 0, reset = 1;
    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // small 4x4 instance
    logic       s_start = 0, s_busy, s_done, s_ival = 0, s_irdy, s_wren, s_ovalid, s_ordy = 1;
    logic [7:0] s_idata = 0, s_wrdata, s_rddata, s_odata;
    logic [1:0] s_wrcol, s_wrrow, s_rdcol, s_rdrow;
    logic [7:0] s_mem [16];
    int         s_dones = 0;

    middle_ram_sequencer #(.WIDTH_BITS(2), .HEIGHT_BITS(2)) u_small (
        .clock(clock), .reset(reset), .iStart(s_start), .oBusy(s_busy), .oDone(s_done),
        .iInValid(s_ival), .iInData(s_idata), .oInReady(s_irdy), .oWren(s_wren),
        .oWrcol(s_wrcol), .oWrrow(s_wrrow), .oWrdata(s_wrdata), .oRdcol(s_rdcol),
        .oRdrow(s_rdrow), .iRddata(s_rddata), .oOutValid(s_ovalid), .oOutData(s_odata),
        .iOutReady(s_ordy));

    always @(posedge clock) begin
        if (s_wren === 1'b1) s_mem[{s_wrrow, s_wrcol}] <= s_wrdata;
        s_rddata <= s_mem[{s_rdrow, s_rdcol}];
        if (s_done === 1'b1) s_dones <= s_dones + 1;
    end

    // large 32x16 instance
    logic          b_start = 0, b_busy, b_done, b_ival = 0, b_irdy, b_wren, b_ovalid, b_ordy = 1;
    logic [7:0]    b_idata = 0, b_wrdata, b_rddata, b_odata;
    logic [BW-1:0] b_wrcol, b_rdcol;
    logic [BH-1:0] b_wrrow, b_rdrow;
    logic [7:0]    b_mem [BN];

    middle_ram_sequencer #(.WIDTH_BITS(BW), .HEIGHT_BITS(BH)) u_big (
        .clock(clock), .reset(reset), .iStart(b_start), .oBusy(b_busy), .oDone(b_done),
        .iInValid(b_ival), .iInData(b_idata), .oInReady(b_irdy), .oWren(b_wren),
        .oWrcol(b_wrcol), .oWrrow(b_wrrow), .oWrdata(b_wrdata), .oRdcol(b_rdcol),
        .oRdrow(b_rdrow), .iRddata(b_rddata), .oOutValid(b_ovalid), .oOutData(b_odata),
        .iOutReady(b_ordy));

    always @(posedge clock) begin
        if (b_wren === 1'b1) b_mem[{b_wrrow, b_wrcol}] <= b_wrdata;
        b_rddata <= b_mem[{b_rdrow, b_rdcol}];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 4x4 frame. vpat: 0 = valid every cycle, 1 = valid on alternate cycles.
    task automatic small_frame(input bit rnd, input int vpat, input int stall_pix,
                               input int abort_pix, input bit start_in_write);
        logic [7:0] dat [16];
        int i, cyc, k, st;
        bit ab;
        for (int n = 0; n < 16; n++) dat[n] = rnd ? 8'($urandom) : 8'(n);
        s_start = 1;
        tick;
        s_start = 0;
        chk("busy_at_start", s_busy, 1);
        i = 0; cyc = 0;
        while (i < 16 && cyc < 100) begin
            s_ival  = (vpat == 0) || (cyc % 2 == 0);
            s_idata = dat[i];
            s_start = start_in_write && cyc == 3;
            #1;
            chk("in_ready", s_irdy, 1);
            chk("wren", s_wren, s_ival);
            if (s_ival) chk("wr_addr", {s_wrrow, s_wrcol}, i[3:0]);
            tick;
            if (s_ival) i++;
            cyc++;
        end
        s_start = 0;
        chk("wr_cycles", cyc, (vpat == 0) ? 16 : 31);
        s_ival = 1;  // must be ignored from here on
        #1;
        chk("rd_entry", {s_irdy, s_wren, s_ovalid, s_rdrow, s_rdcol}, 0);
        k = 0; cyc = 0; st = 0; ab = 0;
        while (k < 16 && cyc < 100 && !ab) begin
            s_ordy = !(k == stall_pix && st < 3);
            #1;
            chk("out_valid", s_ovalid, cyc > 0);
            chk("no_done_in_read", s_done, 0);
            chk("no_wr_in_read", s_wren, 0);
            if (s_ovalid) chk("out_data", s_odata, dat[k]);
            if (s_ovalid && !s_ordy) begin
                chk("stall_addr", {s_rdrow, s_rdcol}, k[3:0]);
                st++;
            end
            if (k == abort_pix && s_ovalid) begin
                reset = 1;
                tick;
                reset = 0;
                s_ival = 0;
                #1;
                chk("abort_outs", {s_busy, s_done, s_irdy, s_wren, s_ovalid,
                                   s_wrcol, s_wrrow, s_rdcol, s_rdrow}, 0);
                ab = 1;
            end else begin
                if (s_ovalid && s_ordy) k++;
                tick;
                cyc++;
            end
        end
        s_ival = 0;
        s_ordy = 1;
        if (!ab) begin
            chk("rd_cycles", cyc, 17 + st);
            chk("done_pulse", {s_done, s_busy, s_ovalid}, 3'b110);
            tick;
            chk("back_idle", {s_done, s_busy}, 0);
        end
    endtask

    task automatic big_frame;
        logic [7:0] dat [BN];
        int i, cyc, k;
        for (int n = 0; n < BN; n++) dat[n] = 8'($urandom);
        b_start = 1;
        tick;
        b_start = 0;
        i = 0; cyc = 0;
        while (i < BN && cyc < 5000) begin
            b_ival  = ($urandom % 4) != 0;
            b_idata = dat[i];
            #1;
            chk("b_wren", b_wren, b_ival);
            if (b_ival) chk("b_wr_addr", {b_wrrow, b_wrcol}, i);
            tick;
            if (b_ival) i++;
            cyc++;
        end
        b_ival = 0;
        #1;
        chk("b_rd_entry", {b_irdy, b_ovalid}, 0);
        k = 0; cyc = 0;
        while (k < BN && cyc < 5000) begin
            b_ordy = ($urandom % 3) != 0;
            #1;
            chk("b_out_valid", b_ovalid, cyc > 0);
            if (b_ovalid) chk("b_out_data", b_odata, dat[k]);
            if (b_ovalid && !b_ordy) chk("b_stall_addr", {b_rdrow, b_rdcol}, k);
            if (b_ovalid && b_ordy) k++;
            tick;
            cyc++;
        end
        b_ordy = 1;
        chk("b_pixel_count", k, BN);
        chk("b_done", {b_done, b_busy}, 2'b11);
        tick;
        chk("b_idle", {b_done, b_busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        reset = 0;
        #1;
        chk("reset_outs", {s_busy, s_done, s_irdy, s_wren, s_ovalid,
                           s_wrcol, s_wrrow, s_rdcol, s_rdrow}, 0);
        small_frame(0, 0, -1, -1, 0);   // index data, no stalls
        chk("dones_1", s_dones, 1);
        small_frame(1, 0, 5, -1, 0);    // pixel 5 stalled 3 cycles
        chk("dones_2", s_dones, 2);
        small_frame(1, 1, -1, -1, 1);   // toggling valid, stray iStart in WRITE
        chk("dones_3", s_dones, 3);
        small_frame(1, 0, -1, 7, 0);    // reset mid-read at pixel 7
        tick;
        chk("dones_abort", s_dones, 3);
        small_frame(1, 0, -1, -1, 0);   // fresh frame after abort
        chk("dones_4", s_dones, 4);
        s_start = 1;
        reset = 1;
        tick;
        s_start = 0;
        reset = 0;
        #1;
        chk("start_with_reset", s_busy, 0);
        tick;
        chk("start_with_reset_2", {s_busy, s_done}, 0);
        chk("dones_final", s_dones, 4);
        big_frame;
        big_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/middle_ram_sequencer.md
MIDDLE_RAM_SEQUENCER -- requirements
Module: middle_ram_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 8, log2 of the frame width (256 columns).
REQ-002 SHALL have parameter HEIGHT_BITS, default 8, log2 of the frame height (256 rows).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- iStart  in  1  one-cycle pulse that starts one write-then-read frame.
- oBusy  out  1  high from the start of a frame until DONE is left.
- oDone  out  1  one-cycle pulse when the last read pixel is accepted.
- iInValid  in  1  producer pixel valid.
- iInData  in  8  producer pixel value.
- oInReady  out  1  sequencer accepts a producer pixel this cycle.
- oWren  out  1  middle-RAM write enable.
- oWrcol  out  WIDTH_BITS  middle-RAM write X.
- oWrrow  out  HEIGHT_BITS  middle-RAM write Y.
- oWrdata  out  8  middle-RAM write data.
- oRdcol  out  WIDTH_BITS  middle-RAM read X.
- oRdrow  out  HEIGHT_BITS  middle-RAM read Y.
- iRddata  in  8  middle-RAM read data, valid one cycle after the address.
- oOutValid  out  1  consumer pixel valid.
- oOutData  out  8  consumer pixel value (equals iRddata).
- iOutReady  in  1  consumer accepts the pixel.

Function
REQ-005 SHALL implement the states IDLE, WRITE, READ, DRAIN and DONE.
REQ-006 In IDLE, iStart=1 SHALL move to WRITE with the write counters at (0,0); iStart SHALL be ignored in every other state.
REQ-007 SHALL assert oInReady only in WRITE; oWren SHALL equal iInValid & oInReady, combinationally.
REQ-008 oWrcol and oWrrow SHALL present the write counter combinationally; oWrdata SHALL equal iInData.
REQ-009 Each write handshake SHALL increment the column; column wrap to 0 SHALL increment the row.
REQ-010 When the write at (2^WIDTH_BITS-1, 2^HEIGHT_BITS-1) completes, the FSM SHALL enter READ next cycle with the read counters at (0,0).
REQ-011 In READ, the address on oRdcol/oRdrow SHALL advance in raster order every cycle the output is not stalled.
REQ-012 Stalled means oOutValid=1 & iOutReady=0.
REQ-013 While stalled, oRdcol/oRdrow SHALL re-present the address of the pixel currently on oOutData, so iRddata stays stable.
REQ-014 oOutValid SHALL rise exactly one cycle after the first read address is issued (one-cycle RAM latency).
REQ-015 oOutValid SHALL stay high until the last pixel is accepted, with no bubbles unless stalled.
REQ-016 After the last address (max,max) is issued, the FSM SHALL enter DRAIN and hold that address.
REQ-017 DRAIN SHALL exit to DONE on acceptance of the last pixel.
REQ-018 DONE SHALL last exactly one cycle with oDone=1, then return to IDLE.
REQ-019 Consumer pixels SHALL be accepted in order (0,0),(1,0)..(max,0),(0,1)..(max,max): exactly 2^(WIDTH_BITS+HEIGHT_BITS) pixels per frame.
REQ-020 oBusy SHALL be high in WRITE, READ, DRAIN and DONE.
REQ-021 Counters SHALL be exactly WIDTH_BITS and HEIGHT_BITS wide and wrap modulo 2^n.
REQ-022 Outside WRITE, oWren SHALL be 0.
REQ-023 Outside READ/DRAIN, oOutValid SHALL be 0.
REQ-024 iInValid=1 outside WRITE SHALL neither write nor advance any counter.

Reset
REQ-025 reset=1 SHALL force IDLE, zero all counters and drive oBusy=0, oDone=0, oInReady=0, oWren=0, oOutValid=0, oWrcol=0, oWrrow=0, oRdcol=0, oRdrow=0 on the next edge, regardless of state.
REQ-026 reset SHALL take priority over iStart in the same cycle.
REQ-027 A frame aborted by reset SHALL not emit oDone, and the next iStart SHALL begin a fresh frame at (0,0).

Verification
REQ-028 SHALL cover: WIDTH_BITS=HEIGHT_BITS=2, iInValid always 1 with data = index 0..15, iOutReady always 1 -> 16 writes in 16 cycles; oOutValid rises 1 cycle after READ entry; output 0..15 with no gaps; oDone one cycle after pixel 15 accepted.
REQ-029 SHALL cover: same frame with iOutReady low for 3 cycles while pixel 5 is presented -> oOutData holds 5 for those cycles and oRdcol/oRdrow hold (1,1); no pixel is lost or duplicated.
REQ-030 SHALL cover: iInValid toggling 1,0 during WRITE -> a write occurs only on valid cycles, final row/col wrap occurs at the 16th write, READ is entered only after it.
REQ-031 SHALL cover: reset asserted mid-READ at pixel 7 -> next cycle all outputs are 0 and the FSM is in IDLE; a new iStart completes a full frame and oDone pulses once.
REQ-032 SHALL cover: iStart pulsed during WRITE, and iStart together with reset -> both ignored; the frame count is unchanged.
REQ-033 SHALL cover: default 256x256 frame with a random consumer stall pattern -> 65536 pixels out, matching the written data in raster order.
